// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT stream controller.
// The config word encodes direction in bit 0 (1 = forward).
package fft_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, CFG, SEND, WAIT} state_t;

    localparam logic [7:0] CFG_FWD = 8'h01;
    localparam logic [7:0] CFG_INV = 8'h00;

    function automatic logic [7:0] cfg_word(input logic inv);
        return inv ? CFG_INV : CFG_FWD;
    endfunction

    // Counter width that stays legal when v is 0..2.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fft_axis_frame_tx.sv
// Frame latch plus AXI-Stream sender: replays the latched samples 0..N-1
// as {imag, real} beats, tlast on the final sample.
module fft_axis_frame_tx #(
    parameter int FFT_POINTS = 16,
    parameter int DATA_WIDTH = 24
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_load,
    input  logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] i_re,
    input  logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] i_im,
    input  logic                                  i_go,
    input  logic                                  i_abort,
    input  logic                                  i_tready,
    output logic [2*DATA_WIDTH-1:0]               o_tdata,
    output logic                                  o_tvalid,
    output logic                                  o_tlast,
    output logic                                  o_last_xfer
);

    localparam int IW = $clog2(FFT_POINTS);

    logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] r_re, r_im;
    logic [IW-1:0]                         r_idx;
    logic                                  r_vld;
    logic                                  w_last;

    assign w_last = (r_idx == IW'(FFT_POINTS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_re  <= '0;
            r_im  <= '0;
            r_idx <= '0;
            r_vld <= 1'b0;
        end else begin
            if (i_load) begin
                r_re <= i_re;
                r_im <= i_im;
            end
            // Abort wins: an early frame end on the receive side stops sending at once.
            if (i_abort) begin
                r_vld <= 1'b0;
            end else if (i_go) begin
                r_vld <= 1'b1;
                r_idx <= '0;
            end else if (r_vld && i_tready) begin
                if (w_last) r_vld <= 1'b0;
                else        r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign o_tdata     = {r_im[r_idx], r_re[r_idx]};
    assign o_tvalid    = r_vld;
    assign o_tlast     = r_vld && w_last;
    assign o_last_xfer = r_vld && i_tready && w_last;

endmodule

// File: rtl/fft_stream_controller.sv
// Frame controller for an external AXI-Stream FFT core: config beat, sample
// stream out, result capture with tlast checking and an idle watchdog.
module fft_stream_controller
    import fft_ctrl_pkg::*;
#(
    parameter int FFT_POINTS     = 16,
    parameter int DATA_WIDTH     = 24,
    parameter int OUT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  inverse,
    input  logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] in_re,
    input  logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] in_im,
    output logic [FFT_POINTS-1:0][OUT_WIDTH-1:0]  out_re,
    output logic [FFT_POINTS-1:0][OUT_WIDTH-1:0]  out_im,
    output logic                                  out_valid,
    output logic                                  done,
    output logic                                  busy,
    output logic                                  start_dropped,
    output logic                                  err_tlast,
    output logic                                  err_timeout,
    output logic [7:0]                            cfg_tdata,
    output logic                                  cfg_tvalid,
    input  logic                                  cfg_tready,
    output logic [2*DATA_WIDTH-1:0]               s_tdata,
    output logic                                  s_tvalid,
    input  logic                                  s_tready,
    output logic                                  s_tlast,
    input  logic [2*OUT_WIDTH-1:0]                m_tdata,
    input  logic                                  m_tvalid,
    output logic                                  m_tready,
    input  logic                                  m_tlast
);

    localparam int IW  = $clog2(FFT_POINTS);
    localparam int RXW = IW + 1;
    localparam int WDW = clog2_min1(TIMEOUT_CYCLES + 1);

    state_t         r_state;
    logic [RXW-1:0] r_rx;
    logic [WDW-1:0] r_wdog;
    logic           r_mrdy;

    logic w_start_ok, w_cfg_xfer, w_s_xfer, w_m_xfer, w_any_xfer;
    logic w_rx_last, w_frame_end, w_tlast_bad, w_timeout;
    logic w_go, w_abort, w_s_last;

    assign w_start_ok  = start && (r_state == IDLE);
    assign w_cfg_xfer  = cfg_tvalid && cfg_tready;
    assign w_s_xfer    = s_tvalid && s_tready;
    assign w_m_xfer    = m_tvalid && r_mrdy;
    assign w_any_xfer  = w_cfg_xfer || w_s_xfer || w_m_xfer;
    assign w_rx_last   = (r_rx == RXW'(FFT_POINTS - 1));
    // The frame ends on the first beat that either carries tlast or should have.
    assign w_frame_end = w_m_xfer && (m_tlast || w_rx_last);
    assign w_tlast_bad = w_m_xfer && (m_tlast != w_rx_last);
    assign w_timeout   = (TIMEOUT_CYCLES > 0) && (r_state != IDLE) && !w_any_xfer &&
                         (r_wdog == WDW'(TIMEOUT_CYCLES - 1));
    assign w_go        = (r_state == CFG) && w_cfg_xfer;
    assign w_abort     = w_frame_end || w_timeout;

    assign busy     = (r_state != IDLE);
    assign m_tready = r_mrdy;

    fft_axis_frame_tx #(
        .FFT_POINTS (FFT_POINTS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_start_ok),
        .i_re        (in_re),
        .i_im        (in_im),
        .i_go        (w_go),
        .i_abort     (w_abort),
        .i_tready    (s_tready),
        .o_tdata     (s_tdata),
        .o_tvalid    (s_tvalid),
        .o_tlast     (s_tlast),
        .o_last_xfer (w_s_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rx          <= '0;
            r_wdog        <= '0;
            r_mrdy        <= 1'b0;
            out_re        <= '0;
            out_im        <= '0;
            out_valid     <= 1'b0;
            done          <= 1'b0;
            start_dropped <= 1'b0;
            err_tlast     <= 1'b0;
            err_timeout   <= 1'b0;
            cfg_tdata     <= '0;
            cfg_tvalid    <= 1'b0;
        end else begin
            done          <= 1'b0;
            start_dropped <= start && (r_state != IDLE);

            // Every state change coincides with a transfer or passes through IDLE.
            if (r_state == IDLE || w_any_xfer) r_wdog <= '0;
            else                               r_wdog <= r_wdog + 1'b1;

            if (w_m_xfer) begin
                out_re[r_rx[IW-1:0]] <= m_tdata[OUT_WIDTH-1:0];
                out_im[r_rx[IW-1:0]] <= m_tdata[2*OUT_WIDTH-1:OUT_WIDTH];
                r_rx                 <= r_rx + 1'b1;
            end

            case (r_state)
                IDLE: if (w_start_ok) begin
                    r_state     <= CFG;
                    cfg_tvalid  <= 1'b1;
                    cfg_tdata   <= cfg_word(inverse);
                    out_valid   <= 1'b0;
                    err_tlast   <= 1'b0;
                    err_timeout <= 1'b0;
                    r_rx        <= '0;
                end
                CFG: if (w_cfg_xfer) begin
                    cfg_tvalid <= 1'b0;
                    r_mrdy     <= 1'b1;
                    r_state    <= SEND;
                end
                SEND: if (w_s_last) r_state <= WAIT;
                default: ;
            endcase

            if (w_frame_end) begin
                r_mrdy    <= 1'b0;
                done      <= 1'b1;
                out_valid <= !w_tlast_bad;
                err_tlast <= w_tlast_bad;
                r_state   <= IDLE;
            end else if (w_timeout) begin
                r_mrdy      <= 1'b0;
                cfg_tvalid  <= 1'b0;
                done        <= 1'b1;
                err_timeout <= 1'b1;
                r_state     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fft_stream_controller.sv
// Directed bench for fft_stream_controller with a behavioural echo core:
// latency 5, sign-extends each input sample, tlast on a configurable beat.
module tb_fft_stream_controller;

    localparam int N   = 16;
    localparam int DW  = 24;
    localparam int OW  = 32;
    localparam int TO  = 64;
    localparam int LAT = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic inverse = 1'b0;
    logic [N-1:0][DW-1:0] in_re = '0;
    logic [N-1:0][DW-1:0] in_im = '0;
    logic [N-1:0][OW-1:0] out_re, out_im;
    logic out_valid, done, busy, start_dropped, err_tlast, err_timeout;
    logic [7:0] cfg_tdata;
    logic cfg_tvalid;
    logic cfg_tready = 1'b1;
    logic [2*DW-1:0] s_tdata;
    logic s_tvalid, s_tlast;
    logic s_tready = 1'b1;
    logic [2*OW-1:0] m_tdata = '0;
    logic m_tvalid = 1'b0;
    logic m_tlast = 1'b0;
    logic m_tready;

    int checks, errors;

    // echo-core model state
    typedef struct { logic [2*OW-1:0] d; int t; int seq; } beat_t;
    beat_t q[$];
    int  cyc, push_cnt, cur_seq = -1;
    bit  mdl_flush, mdl_silent, stall_en;
    int  tlast_beat = N - 1;

    // monitor state
    logic [DW-1:0] exp_re[N], exp_im[N];
    int  cfg_cnt, s_cnt, s_idx, tlast_cnt, tlast_idx, s_bad, stab_bad;
    int  done_cnt, done_cyc, s_last_cyc, sd_cnt;
    logic [7:0] cfg_last;
    bit  stall_prev;
    logic [2*DW-1:0] stall_data;

    fft_stream_controller #(
        .FFT_POINTS(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .inverse(inverse),
        .in_re(in_re), .in_im(in_im), .out_re(out_re), .out_im(out_im),
        .out_valid(out_valid), .done(done), .busy(busy), .start_dropped(start_dropped),
        .err_tlast(err_tlast), .err_timeout(err_timeout),
        .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] sx(input logic [DW-1:0] v);
        return OW'($signed(v));
    endfunction

    // Observe handshakes with pre-edge values; also feeds the echo queue.
    always @(posedge clk) begin
        cyc++;
        if (mdl_flush) begin q.delete(); push_cnt = 0; end
        if (cfg_tvalid && cfg_tready) begin cfg_cnt++; cfg_last = cfg_tdata; s_idx = 0; end
        if (s_tvalid && s_tready) begin
            if (s_idx < N && s_tdata !== {exp_im[s_idx], exp_re[s_idx]}) s_bad++;
            if (s_tlast) begin tlast_cnt++; tlast_idx = s_idx; end
            q.push_back('{d: {sx(s_tdata[2*DW-1:DW]), sx(s_tdata[DW-1:0])}, t: cyc, seq: push_cnt});
            push_cnt++; s_cnt++; s_idx++; s_last_cyc = cyc;
        end
        if (m_tvalid && m_tready && q.size() > 0) void'(q.pop_front());
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (start_dropped) sd_cnt++;
        if (stall_prev && s_tvalid && s_tdata !== stall_data) stab_bad++;
        stall_prev = s_tvalid && !s_tready;
        stall_data = s_tdata;
    end

    // Core-side drive on the falling edge; a presented beat is held until popped.
    always @(negedge clk) begin
        s_tready   = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        cfg_tready = 1'b1;
        if (mdl_flush) begin
            m_tvalid = 1'b0; m_tlast = 1'b0; cur_seq = -1;
        end else if (!(m_tvalid && q.size() > 0 && q[0].seq == cur_seq)) begin
            m_tvalid = 1'b0; m_tlast = 1'b0;
            if (!mdl_silent && q.size() > 0 && cyc >= q[0].t + LAT &&
                (!stall_en || $urandom_range(0, 1) == 1)) begin
                m_tvalid = 1'b1;
                m_tdata  = q[0].d;
                m_tlast  = (q[0].seq == tlast_beat);
                cur_seq  = q[0].seq;
            end
        end
    end

    task automatic set_frame(input int pat);
        for (int i = 0; i < N; i++) begin
            if (pat == 0) begin exp_re[i] = DW'(i); exp_im[i] = DW'(-i); end
            else begin exp_re[i] = DW'(32'h800000 + i * 4099); exp_im[i] = DW'(32'h700000 + i * 4369); end
            in_re[i] = exp_re[i];
            in_im[i] = exp_im[i];
        end
    endtask

    task automatic flush();
        mdl_flush = 1'b1;
        repeat (3) @(negedge clk);
        mdl_flush = 1'b0;
    endtask

    task automatic kick(input logic inv);
        @(negedge clk); start = 1'b1; inverse = inv;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, out_valid, start_dropped, err_tlast, err_timeout} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 000000", {busy, done, out_valid, start_dropped, err_tlast, err_timeout}); end
        checks++; if ({cfg_tvalid, s_tvalid, s_tlast, m_tready} !== 4'b0) begin
            errors++; $display("FAIL reset_hs got %b exp 0000", {cfg_tvalid, s_tvalid, s_tlast, m_tready}); end
        checks++; if (cfg_tdata !== 8'h00 || s_tdata !== '0) begin
            errors++; $display("FAIL reset_data cfg %h s %h exp 0", cfg_tdata, s_tdata); end
        checks++; if (out_re !== '0 || out_im !== '0) begin
            errors++; $display("FAIL reset_out_arrays nonzero exp 0"); end
        reset = 1'b0;
    endtask

    task automatic test_forward();
        int c0, s0, t0, d0, b0; bit seen;
        set_frame(0); flush();
        c0 = cfg_cnt; s0 = s_cnt; t0 = tlast_cnt; d0 = done_cnt; b0 = s_bad;
        checks++; if (cfg_tvalid !== 1'b0) begin errors++; $display("FAIL t1_cfg_pre got %b exp 0", cfg_tvalid); end
        kick(1'b0);
        checks++; if (cfg_tvalid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL t1_cfg_after_start cfg_tvalid %b busy %b exp 1 1", cfg_tvalid, busy); end
        checks++; if (cfg_tdata !== 8'h01) begin errors++; $display("FAIL t1_cfg_tdata got %h exp 01", cfg_tdata); end
        wait_done(400, seen);
        checks++; if (!seen) begin errors++; $display("FAIL t1_done_timeout got 0 exp 1"); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_width got %b exp 0", done); end
        checks++; if (cfg_cnt - c0 != 1) begin errors++; $display("FAIL t1_cfg_beats got %0d exp 1", cfg_cnt - c0); end
        checks++; if (s_cnt - s0 != N) begin errors++; $display("FAIL t1_s_beats got %0d exp %0d", s_cnt - s0, N); end
        checks++; if (tlast_cnt - t0 != 1 || tlast_idx != N - 1) begin
            errors++; $display("FAIL t1_s_tlast count %0d idx %0d exp 1 %0d", tlast_cnt - t0, tlast_idx, N - 1); end
        checks++; if (s_bad != b0) begin errors++; $display("FAIL t1_s_tdata bad %0d exp 0", s_bad - b0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL t1_done_pulses got %0d exp 1", done_cnt - d0); end
        checks++; if ({out_valid, err_tlast, err_timeout, busy, m_tready} !== 5'b10000) begin
            errors++; $display("FAIL t1_status got %b exp 10000", {out_valid, err_tlast, err_timeout, busy, m_tready}); end
        for (int i = 0; i < N; i++) begin
            checks++; if (out_re[i] !== OW'(i) || out_im[i] !== OW'(-i)) begin
                errors++; $display("FAIL t1_out[%0d] got %h/%h exp %h/%h", i, out_re[i], out_im[i], OW'(i), OW'(-i)); end
        end
    endtask

    task automatic test_stalls();
        int s0, b0, st0, d0; bit seen;
        set_frame(1); flush();
        s0 = s_cnt; b0 = s_bad; st0 = stab_bad; d0 = done_cnt;
        stall_en = 1'b1;
        kick(1'b0);
        wait_done(1000, seen);
        stall_en = 1'b0;
        @(negedge clk);
        checks++; if (!seen) begin errors++; $display("FAIL t2_done_timeout got 0 exp 1"); end
        checks++; if (s_cnt - s0 != N) begin errors++; $display("FAIL t2_s_beats got %0d exp %0d", s_cnt - s0, N); end
        checks++; if (stab_bad != st0) begin errors++; $display("FAIL t2_s_stable changes %0d exp 0", stab_bad - st0); end
        checks++; if (s_bad != b0) begin errors++; $display("FAIL t2_s_tdata bad %0d exp 0", s_bad - b0); end
        checks++; if (done_cnt - d0 != 1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL t2_done done %0d out_valid %b exp 1 1", done_cnt - d0, out_valid); end
        for (int i = 0; i < N; i++) begin
            checks++; if (out_re[i] !== sx(exp_re[i]) || out_im[i] !== sx(exp_im[i])) begin
                errors++; $display("FAIL t2_out[%0d] got %h/%h exp %h/%h", i, out_re[i], out_im[i], sx(exp_re[i]), sx(exp_im[i])); end
        end
    endtask

    task automatic test_inverse_drop();
        int s0, sd0, d0; bit seen;
        set_frame(0); flush();
        s0 = s_cnt; sd0 = sd_cnt; d0 = done_cnt;
        kick(1'b1);
        checks++; if (cfg_tdata !== 8'h00) begin errors++; $display("FAIL t3_cfg_tdata got %h exp 00", cfg_tdata); end
        for (int k = 0; k < 100 && s_cnt - s0 < 4; k++) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(400, seen);
        @(negedge clk);
        checks++; if (!seen) begin errors++; $display("FAIL t3_done_timeout got 0 exp 1"); end
        checks++; if (cfg_last !== 8'h00) begin errors++; $display("FAIL t3_cfg_beat got %h exp 00", cfg_last); end
        checks++; if (sd_cnt - sd0 != 1) begin errors++; $display("FAIL t3_start_dropped got %0d exp 1", sd_cnt - sd0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL t3_done_pulses got %0d exp 1", done_cnt - d0); end
        checks++; if (s_cnt - s0 != N || out_valid !== 1'b1) begin
            errors++; $display("FAIL t3_frame s_beats %0d out_valid %b exp %0d 1", s_cnt - s0, out_valid, N); end
        checks++; if (out_re[N-1] !== OW'(N - 1) || out_im[N-1] !== OW'(1 - N)) begin
            errors++; $display("FAIL t3_out_last got %h/%h exp %h/%h", out_re[N-1], out_im[N-1], OW'(N - 1), OW'(1 - N)); end
    endtask

    task automatic test_tlast_err();
        int d0; bit seen;
        set_frame(0); flush();
        d0 = done_cnt;
        tlast_beat = 9;
        kick(1'b0);
        wait_done(400, seen);
        checks++; if (!seen) begin errors++; $display("FAIL t4_done_timeout got 0 exp 1"); end
        checks++; if ({err_tlast, out_valid, busy} !== 3'b100) begin
            errors++; $display("FAIL t4_status err/valid/busy got %b exp 100", {err_tlast, out_valid, busy}); end
        @(negedge clk);
        checks++; if (done_cnt - d0 != 1 || m_tready !== 1'b0) begin
            errors++; $display("FAIL t4_done pulses %0d m_tready %b exp 1 0", done_cnt - d0, m_tready); end
        checks++; if (out_re[9] !== OW'(9)) begin errors++; $display("FAIL t4_out9 got %h exp 9", out_re[9]); end
        tlast_beat = N - 1;
        set_frame(0); flush();
        kick(1'b0);
        checks++; if (err_tlast !== 1'b0) begin errors++; $display("FAIL t4_err_clear got %b exp 0", err_tlast); end
        wait_done(400, seen);
        checks++; if (!seen || out_valid !== 1'b1 || err_tlast !== 1'b0) begin
            errors++; $display("FAIL t4_recover seen %b out_valid %b err %b exp 1 1 0", seen, out_valid, err_tlast); end
    endtask

    task automatic test_timeout();
        int d0; bit seen;
        set_frame(0); flush();
        d0 = done_cnt;
        mdl_silent = 1'b1;
        kick(1'b0);
        wait_done(400, seen);
        @(negedge clk);
        mdl_silent = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL t5_done_timeout got 0 exp 1"); end
        checks++; if ({err_timeout, err_tlast, out_valid, busy} !== 4'b1000) begin
            errors++; $display("FAIL t5_status got %b exp 1000", {err_timeout, err_tlast, out_valid, busy}); end
        // done is registered at the TO-th edge after the last s xfer; monitor sees it one edge later
        checks++; if (done_cyc - s_last_cyc != TO + 1) begin
            errors++; $display("FAIL t5_latency got %0d exp %0d", done_cyc - s_last_cyc, TO + 1); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL t5_done_pulses got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_async_reset();
        int s0, d0; bit seen;
        set_frame(0); flush();
        s0 = s_cnt;
        kick(1'b0);
        for (int k = 0; k < 200 && s_cnt - s0 < 7; k++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if ({busy, cfg_tvalid, s_tvalid, s_tlast, m_tready, out_valid, done} !== 7'b0) begin
            errors++; $display("FAIL t6_ctrl got %b exp 0000000", {busy, cfg_tvalid, s_tvalid, s_tlast, m_tready, out_valid, done}); end
        checks++; if (s_tdata !== '0 || cfg_tdata !== 8'h00) begin
            errors++; $display("FAIL t6_data s %h cfg %h exp 0", s_tdata, cfg_tdata); end
        checks++; if (out_re !== '0 || out_im !== '0) begin
            errors++; $display("FAIL t6_out_arrays out_re[1] %h exp 0", out_re[1]); end
        flush();
        @(negedge clk); reset = 1'b0;
        d0 = done_cnt;
        kick(1'b0);
        wait_done(400, seen);
        @(negedge clk);
        checks++; if (!seen || done_cnt - d0 != 1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL t6_fresh seen %b pulses %0d out_valid %b exp 1 1 1", seen, done_cnt - d0, out_valid); end
        for (int i = 0; i < N; i++) begin
            checks++; if (out_re[i] !== OW'(i) || out_im[i] !== OW'(-i)) begin
                errors++; $display("FAIL t6_out[%0d] got %h/%h exp %h/%h", i, out_re[i], out_im[i], OW'(i), OW'(-i)); end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_stalls();
        test_inverse_drop();
        test_tlast_err();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
